move_scheduler: RTL

- Arbitrates every piece-motion source in the Tetris game and issues one command at a time to the piece engine over a valid/ready plus result handshake.
- Sources:
  - one-shot key codes from the keypress state machine;
  - soft-drop auto-repeat while S is held;
  - gravity, derived from the per-frame tick.
- Sequences the lock handshake when a downward move is blocked.

---
 rtl/move_scheduler_if.sv | 20 ++
 rtl/move_scheduler.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/move_scheduler_if.sv
// Command / result / lock handshake between the move scheduler and the piece engine.
interface move_scheduler_if;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       cmd_ready;
  logic       result_valid;
  logic       result_blocked;
  logic       lock_req;
  logic       lock_done;

  modport master (
    output cmd_valid, cmd, lock_req,
    input  cmd_ready, result_valid, result_blocked, lock_done
  );

  modport slave (
    input  cmd_valid, cmd, lock_req,
    output cmd_ready, result_valid, result_blocked, lock_done
  );
endinterface

// File: rtl/move_scheduler.sv
// Arbitrates key, soft-drop and gravity motion requests and issues one piece-engine
// command at a time, sequencing the lock handshake when a downward move is blocked.
//
// state | meaning
// IDLE  | choose highest-priority pending request, latch it as cmd
// ISSUE | cmd_valid high, cmd stable until cmd_ready
// WAIT  | waiting for result_valid from the engine
// LOCK  | lock_req on entry cycle, then waiting for lock_done
module move_scheduler #(
  parameter int GRAV_TICKS = 30,
  parameter int SOFT_TICKS = 3
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [3:0]        keypress,
  input  logic              frame_tick,
  input  logic              game_over,
  move_scheduler_if.master  eng,
  output logic              busy
);

  localparam logic [2:0] CMD_NONE   = 3'd0;
  localparam logic [2:0] CMD_ROTATE = 3'd1;
  localparam logic [2:0] CMD_LEFT   = 3'd2;
  localparam logic [2:0] CMD_RIGHT  = 3'd3;
  localparam logic [2:0] CMD_DOWN   = 3'd4;
  localparam logic [2:0] CMD_NEW    = 3'd5;

  localparam logic [5:0] GRAV_LAST = 6'(GRAV_TICKS - 1);
  localparam logic [5:0] SOFT_LAST = 6'(SOFT_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_LOCK} state_t;

  state_t     state, state_n;
  logic [2:0] cmd_q;
  logic       lock_first;
  logic [2:0] key_pend, key_n;
  logic       grav_pend, gp_n, soft_pend, sp_n;
  logic [5:0] grav_cnt, gc_n, soft_cnt, sc_n;
  logic       prev_s;
  logic [2:0] sel_cmd;
  logic       latch, latch_key, latch_down, latch_ng, lock_exit, s_now;

  // Only NEW_GAME may be served once the board has topped out.
  always_comb begin
    sel_cmd = CMD_NONE;
    if (key_pend == 3'd5)                sel_cmd = CMD_NEW;
    else if (!game_over) begin
      if (key_pend == 3'd1)              sel_cmd = CMD_ROTATE;
      else if (key_pend == 3'd2)         sel_cmd = CMD_LEFT;
      else if (key_pend == 3'd4)         sel_cmd = CMD_RIGHT;
      else if (soft_pend || grav_pend)   sel_cmd = CMD_DOWN;
    end
  end

  assign latch      = (state == S_IDLE) && (sel_cmd != CMD_NONE);
  assign latch_down = latch && (sel_cmd == CMD_DOWN);
  assign latch_key  = latch && (sel_cmd != CMD_DOWN);
  assign latch_ng   = latch && (sel_cmd == CMD_NEW);
  assign lock_exit  = (state == S_LOCK) && eng.lock_done;
  assign s_now      = (keypress == 4'd3);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      cmd_q      <= CMD_NONE;
      lock_first <= 1'b0;
    end else begin
      state      <= state_n;
      lock_first <= (state_n == S_LOCK) && (state != S_LOCK);
      if (latch) cmd_q <= sel_cmd;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (latch) state_n = S_ISSUE;
      S_ISSUE: if (eng.cmd_ready) state_n = (cmd_q == CMD_NEW) ? S_IDLE : S_WAIT;
      S_WAIT:  if (eng.result_valid)
                 state_n = (cmd_q == CMD_DOWN && eng.result_blocked) ? S_LOCK : S_IDLE;
      S_LOCK:  if (eng.lock_done) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    eng.cmd_valid = (state == S_ISSUE);
    eng.cmd       = (state == S_ISSUE) ? cmd_q : CMD_NONE;
    eng.lock_req  = (state == S_LOCK) && lock_first;
    busy          = (state != S_IDLE);
  end

  // Pending sources: a request arriving in the latch cycle survives the clear.
  always_comb begin
    key_n = key_pend;
    if (latch_key) key_n = 3'd0;
    case (keypress)
      4'd1, 4'd2, 4'd4: if (key_n != 3'd5) key_n = keypress[2:0];
      4'd5:             key_n = 3'd5;
      default:          ;
    endcase
    if (game_over && key_n != 3'd5) key_n = 3'd0;

    gp_n = grav_pend;
    gc_n = grav_cnt;
    if (latch_down || latch_ng) gp_n = 1'b0;
    if (latch_ng) gc_n = 6'd0;
    else if (!game_over && frame_tick) begin
      if (grav_cnt == GRAV_LAST) begin
        gc_n = 6'd0;
        gp_n = 1'b1;
      end else begin
        gc_n = grav_cnt + 6'd1;
      end
    end
    if (lock_exit || game_over) gp_n = 1'b0;

    sp_n = soft_pend;
    sc_n = soft_cnt;
    if (latch_down || latch_ng) sp_n = 1'b0;
    if (latch_ng) sc_n = 6'd0;
    if (!s_now) sc_n = 6'd0;
    else if (!prev_s) begin
      sp_n = 1'b1;
      sc_n = 6'd0;
    end else if (frame_tick && !latch_ng) begin
      if (soft_cnt == SOFT_LAST) begin
        sc_n = 6'd0;
        sp_n = 1'b1;
      end else begin
        sc_n = soft_cnt + 6'd1;
      end
    end
    if (lock_exit || game_over) sp_n = 1'b0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      key_pend  <= 3'd0;
      grav_pend <= 1'b0;
      soft_pend <= 1'b0;
      grav_cnt  <= 6'd0;
      soft_cnt  <= 6'd0;
      prev_s    <= 1'b0;
    end else begin
      key_pend  <= key_n;
      grav_pend <= gp_n;
      soft_pend <= sp_n;
      grav_cnt  <= gc_n;
      soft_cnt  <= sc_n;
      prev_s    <= s_now;
    end
  end

endmodule
